keyboard_event_decoder: RTL and testbench

Consumes the byte stream of the raw PS/2 keyboard controller (one-cycle `dataReady` strobe plus `dataOut` byte) and assembles scan-code set 2 prefix sequences (E0, F0) into single key events. Events carry make/break and extended flags and are buffered in a small first-word-fall-through FIFO. A CPU-side bus adapter pops the events. The block sits directly downstream of the raw keyboard controller in the keyboard subsystem.

---
 rtl/keyboard_event_decoder_if.sv | 23 ++
 rtl/keyboard_event_decoder.sv | 127 ++++++++++++
 tb/tb_keyboard_event_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/keyboard_event_decoder_if.sv
// Byte-in / event-out bundle for keyboard_event_decoder.
// The slave modport is the decoder side; the master modport is the producer/consumer side.
interface keyboard_event_decoder_if;
    logic       dataReady;
    logic [7:0] dataIn;
    logic       readEnable;
    logic       clearOverflow;
    logic       eventValid;
    logic [7:0] eventCode;
    logic       eventExtended;
    logic       eventBreak;
    logic       overflow;

    modport slave (
        input  dataReady, dataIn, readEnable, clearOverflow,
        output eventValid, eventCode, eventExtended, eventBreak, overflow
    );

    modport master (
        output dataReady, dataIn, readEnable, clearOverflow,
        input  eventValid, eventCode, eventExtended, eventBreak, overflow
    );
endinterface

// File: rtl/keyboard_event_decoder.sv
// Folds PS/2 set-2 E0/F0 prefixes into key events held in a first-word-fall-through FIFO.
// Optional macro KEYBOARD_EVENT_OVERFLOW_EN enables the sticky overflow flag.
module keyboard_event_decoder #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input logic                     clock,
    input logic                     reset,
    keyboard_event_decoder_if.slave bus
);
    localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2-1:0] PtrOne   = 1;
    localparam logic [FIFO_DEPTH_LOG2:0]   CntOne   = 1;
    localparam logic [FIFO_DEPTH_LOG2:0]   CntDepth = (FIFO_DEPTH_LOG2 + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StGotE0, StGotF0, StGotE0F0} state_e;

    state_e state_q, state_d;
    logic   emit, emit_ext, emit_brk;

    logic [9:0]                 mem_q [Depth];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic                       full, empty, push, pop, drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (bus.dataReady) begin
            unique case (bus.dataIn)
                8'hE0: begin
                    unique case (state_q)
                        StIdle:  state_d = StGotE0;
                        StGotF0: state_d = StGotE0F0;
                        default: state_d = state_q;
                    endcase
                end
                8'hF0: begin
                    unique case (state_q)
                        StIdle:  state_d = StGotF0;
                        StGotE0: state_d = StGotE0F0;
                        default: state_d = state_q;
                    endcase
                end
                default: begin
                    emit     = 1'b1;
                    emit_ext = (state_q == StGotE0) || (state_q == StGotE0F0);
                    emit_brk = (state_q == StGotF0) || (state_q == StGotE0F0);
                    state_d  = StIdle;
                end
            endcase
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CntDepth);
    assign pop   = bus.readEnable && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign push  = emit && (!full || pop);
    assign drop  = emit && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        if (push && !pop)      count_d = count_q + CntOne;
        else if (pop && !push) count_d = count_q - CntOne;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {emit_ext, emit_brk, bus.dataIn};
        end
    end

    assign bus.eventValid    = !empty;
    assign bus.eventExtended = !empty && mem_q[rd_ptr_q][9];
    assign bus.eventBreak    = !empty && mem_q[rd_ptr_q][8];
    assign bus.eventCode     = empty ? 8'h00 : mem_q[rd_ptr_q][7:0];

`ifdef KEYBOARD_EVENT_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (drop)                   overflow_d = 1'b1;
        else if (bus.clearOverflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    logic [1:0] unused_ovf;
    assign unused_ovf   = {bus.clearOverflow, drop};
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_keyboard_event_decoder.sv
// Directed bench for keyboard_event_decoder: prefix folding, FIFO order, overflow and reset.
module tb_keyboard_event_decoder;
`ifdef KEYBOARD_EVENT_OVERFLOW_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    keyboard_event_decoder_if bus ();

    keyboard_event_decoder #(
        .FIFO_DEPTH_LOG2(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge too.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clock);
        bus.dataReady = 1'b1;
        bus.dataIn    = b;
        @(negedge clock);
        bus.dataReady = 1'b0;
        bus.dataIn    = 8'h00;
    endtask

    task automatic pop_expect(input string tag, input logic ext, input logic brk,
                              input logic [7:0] code);
        check({tag, "_valid"}, 32'(bus.eventValid), 32'd1);
        check({tag, "_code"},  32'(bus.eventCode), 32'(code));
        check({tag, "_ext"},   32'(bus.eventExtended), 32'(ext));
        check({tag, "_brk"},   32'(bus.eventBreak), 32'(brk));
        bus.readEnable = 1'b1;
        @(negedge clock);
        bus.readEnable = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.dataReady     = 1'b0;
        bus.dataIn        = 8'h00;
        bus.readEnable    = 1'b0;
        bus.clearOverflow = 1'b0;
        do_reset();

        check("rst_valid", 32'(bus.eventValid), 32'd0);
        check("rst_code",  32'(bus.eventCode), 32'h00);
        check("rst_ext",   32'(bus.eventExtended), 32'd0);
        check("rst_brk",   32'(bus.eventBreak), 32'd0);
        check("rst_ovf",   32'(bus.overflow), 32'd0);

        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("idle_valid", 32'(bus.eventValid), 32'd0);
            check("idle_ovf",   32'(bus.overflow), 32'd0);
        end

        // Pop on empty must not underflow the pointers.
        bus.readEnable = 1'b1;
        @(negedge clock);
        bus.readEnable = 1'b0;
        check("empty_pop_valid", 32'(bus.eventValid), 32'd0);

        strobe(8'h1C);
        pop_expect("single", 1'b0, 1'b0, 8'h1C);
        check("single_after_pop", 32'(bus.eventValid), 32'd0);

        strobe(8'hF0);
        check("prefix_f0_silent", 32'(bus.eventValid), 32'd0);
        strobe(8'h1C);
        strobe(8'hE0);
        strobe(8'h75);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h75);
        pop_expect("seq_brk",    1'b0, 1'b1, 8'h1C);
        pop_expect("seq_ext",    1'b1, 1'b0, 8'h75);
        pop_expect("seq_extbrk", 1'b1, 1'b1, 8'h75);
        check("seq_empty", 32'(bus.eventValid), 32'd0);

        // F0 then E0 is tolerated and still yields extended break.
        strobe(8'hF0);
        strobe(8'hE0);
        strobe(8'h14);
        pop_expect("f0e0", 1'b1, 1'b1, 8'h14);

        strobe(8'hE0);
        do_reset();
        strobe(8'h1C);
        pop_expect("rst_prefix", 1'b0, 1'b0, 8'h1C);
        check("rst_prefix_empty", 32'(bus.eventValid), 32'd0);

        for (int i = 1; i <= 9; i++) strobe(8'(i));
        check("ovf_set", 32'(bus.overflow), 32'(OvfEn));
        // Another drop coinciding with clear keeps the flag set.
        @(negedge clock);
        bus.dataReady     = 1'b1;
        bus.dataIn        = 8'h0B;
        bus.clearOverflow = 1'b1;
        @(negedge clock);
        bus.dataReady     = 1'b0;
        bus.clearOverflow = 1'b0;
        check("ovf_drop_wins", 32'(bus.overflow), 32'(OvfEn));
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("full_%0d", i), 1'b0, 1'b0, 8'(i));
        check("full_drained", 32'(bus.eventValid), 32'd0);
        check("ovf_sticky", 32'(bus.overflow), 32'(OvfEn));
        bus.clearOverflow = 1'b1;
        @(negedge clock);
        bus.clearOverflow = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 32'd0);

        for (int i = 1; i <= 8; i++) strobe(8'(i));
        @(negedge clock);
        bus.dataReady  = 1'b1;
        bus.dataIn     = 8'h0A;
        bus.readEnable = 1'b1;
        @(negedge clock);
        bus.dataReady  = 1'b0;
        bus.readEnable = 1'b0;
        check("simul_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 2; i <= 8; i++) pop_expect($sformatf("simul_%0d", i), 1'b0, 1'b0, 8'(i));
        pop_expect("simul_last", 1'b0, 1'b0, 8'h0A);
        check("simul_empty", 32'(bus.eventValid), 32'd0);
        check("simul_ovf_end", 32'(bus.overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
